dcache_frame_reader: RTL

- Downstream consumer of the DDR write-fill stage. After the fill completes, it reads the frame back from DDR over the same cache-side memory port, one 256-bit line at a time.
- Each line carries eight 32-bit words, each holding one byte in its low 8 bits. The block unpacks these bytes and streams them out with a valid/ready handshake, for the display or checker path.
- Two line buffers hide DDR read latency behind byte streaming.

---
 rtl/dcache_frame_reader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/dcache_frame_reader.sv
// rtl/dcache_frame_reader.sv - reads a frame back from DDR line by line and streams its low bytes
// Optional: FRAME_READ_CHECK_EN enables the zero check on the upper 24 bits of every word.
module dcache_frame_reader #(
  parameter int          NUM_LINES = 38400,
  parameter logic [27:0] BASE_ADDR = 28'h0000000,
  parameter int          ADDR_STEP = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic [27:0]  mem_data_addr1,
  output logic         mem_rw_data1,
  output logic         mem_valid_data1,
  input  logic         mem_ready_data1,
  input  logic [255:0] mem_data_rd1,
  output logic [7:0]   pix_data,
  output logic         pix_valid,
  input  logic         pix_ready,
  output logic         busy,
  output logic         done,
  output logic         err_flag,
  output logic [15:0]  err_cnt
);
  localparam logic [15:0] N_LINES   = 16'(NUM_LINES);
  localparam logic [15:0] LAST_LINE = 16'(NUM_LINES - 1);
  localparam logic [27:0] STEP      = 28'(ADDR_STEP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;
  state_t state, state_nxt;

  logic [255:0] line_buf [2];
  logic         wr_ptr, rd_ptr;
  logic [1:0]   occ;
  logic [15:0]  lines_req, lines_out;
  logic [2:0]   byte_idx;
  logic         capture, pix_fire, release_line, last_fire;
  logic         frame_start, launch_run, launch;

  assign capture      = mem_valid_data1 & mem_ready_data1;
  assign pix_valid    = (occ != 2'd0);
  assign pix_data     = pix_valid ? line_buf[rd_ptr][{byte_idx, 5'd0} +: 8] : 8'h00;
  assign pix_fire     = pix_valid & pix_ready;
  assign release_line = pix_fire & (byte_idx == 3'd7);
  assign last_fire    = release_line & (lines_out == LAST_LINE);
  assign mem_rw_data1 = 1'b0;

  // One request in flight at most; buffered plus outstanding lines never exceed two.
  assign frame_start = (state == S_IDLE) & start;
  assign launch_run  = (state == S_RUN) & ~mem_valid_data1 & (lines_req < N_LINES) & (occ < 2'd2);
  assign launch      = launch_run | (frame_start & (N_LINES != 16'd0));

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (N_LINES == 16'd0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_fire) state_nxt = S_FINISH;
      end
      S_FINISH: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      mem_valid_data1 <= 1'b0;
      mem_data_addr1  <= BASE_ADDR;
      wr_ptr          <= 1'b0;
      rd_ptr          <= 1'b0;
      occ             <= 2'd0;
      lines_req       <= 16'd0;
      lines_out       <= 16'd0;
      byte_idx        <= 3'd0;
    end else begin
      state <= state_nxt;
      if (launch) mem_valid_data1 <= 1'b1;
      else if (capture) mem_valid_data1 <= 1'b0;
      if (frame_start) begin
        mem_data_addr1 <= BASE_ADDR;
        lines_req      <= (N_LINES != 16'd0) ? 16'd1 : 16'd0;
        lines_out      <= 16'd0;
        byte_idx       <= 3'd0;
      end else begin
        if (launch_run) lines_req <= lines_req + 16'd1;
        if (capture) begin
          mem_data_addr1 <= mem_data_addr1 + STEP;
          wr_ptr         <= ~wr_ptr;
        end
        if (pix_fire) byte_idx <= byte_idx + 3'd1;
        if (release_line) begin
          rd_ptr    <= ~rd_ptr;
          lines_out <= lines_out + 16'd1;
        end
        case ({capture, release_line})
          2'b10:   occ <= occ + 2'd1;
          2'b01:   occ <= occ - 2'd1;
          default: occ <= occ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) line_buf[wr_ptr] <= mem_data_rd1;
  end

`ifdef FRAME_READ_CHECK_EN
  logic line_bad;

  always_comb begin
    line_bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (mem_data_rd1[32*k+8 +: 24] != 24'd0) line_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag <= 1'b0;
      err_cnt  <= 16'd0;
    end else if (capture && line_bad) begin
      err_flag <= 1'b1;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign err_flag = 1'b0;
  assign err_cnt  = 16'd0;
`endif

endmodule
